// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: state encoding, program
// entry points and the branch-target table.
package fetch_pkg;

  localparam int PC_W  = 8;
  localparam int IDX_W = 4;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Program 3 is unused and aliases program 0.
  localparam int START_ADDR [4] = '{0, 27, 46, 0};

  localparam int LUT_DEPTH = 16;
  localparam int BRANCH_LUT [LUT_DEPTH] = '{
    2,   // loop
    22,  // lowerloop
    27,  // stringLoop
    30,  // matchLoop
    40,  // found
    41,  // incJ
    47,  // outer
    49,  // inner
    54,  // ijSub
    55,  // compDist
    58,  // incJ2
    0, 0, 0, 0, 0
  };

endpackage

// File: rtl/branch_lut.sv
// Branch-target lookup: maps the short index carried by an instruction to a
// full PC value. Purely combinational.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PC_W  = fetch_pkg::PC_W,
  parameter int IDX_W = fetch_pkg::IDX_W
) (
  input  logic [IDX_W-1:0] idx,
  output logic [PC_W-1:0]  target
);

  // NOTE: target gets a default before the conditional so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    target = '0;
    if (int'(idx) < LUT_DEPTH) target = PC_W'(BRANCH_LUT[idx]);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer: selects a resident program, steps or
// branches the PC under decoder control and reports run/done status.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_W  = fetch_pkg::PC_W,
  parameter int IDX_W = fetch_pkg::IDX_W,
  parameter int CNT_W = fetch_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       prog_sel,
  input  logic             halt,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [IDX_W-1:0] branch_idx,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  state_t          state;
  logic [PC_W-1:0] branch_target;

  branch_lut #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_branch_lut (
    .idx    (branch_idx),
    .target (branch_target)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values; reset is asynchronous and clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      cycle_cnt <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      state     <= RUN;
      pc        <= PC_W'(START_ADDR[prog_sel]);
      cycle_cnt <= '0;
      running   <= 1'b1;
      done      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // The halt cycle still counts as a run cycle.
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
          if (halt) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (!stall) begin
            if (branch_en) pc <= branch_target;
            else           pc <= pc + 1'b1;
          end
        end
        default: ;  // IDLE and DONE hold everything until start
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a reference model predicts every cycle's
// outputs, and each scenario task adds spot checks at the interesting points.
module tb_fetch_ctrl;

  typedef struct packed {
    logic [7:0]  pc;
    logic        running;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;

  localparam int SA  [4]  = '{0, 27, 46, 0};
  localparam int LUT [16] = '{2, 22, 27, 30, 40, 41, 47, 49, 54, 55, 58, 0, 0, 0, 0, 0};

  logic        clk = 1'b0;
  logic        rst;
  logic        start, halt, stall, branch_en;
  logic [1:0]  prog_sel;
  logic [3:0]  branch_idx;
  logic [7:0]  pc;
  logic        running, done;
  logic [15:0] cycle_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t    sb_q[$];
  mstate_t m_state;
  int      m_pc, m_cnt;

  fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_sel   (prog_sel),
    .halt       (halt),
    .stall      (stall),
    .branch_en  (branch_en),
    .branch_idx (branch_idx),
    .pc         (pc),
    .running    (running),
    .done       (done),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: compares DUT outputs 1 time unit after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      tests_run++;
      if ({pc, running, done, cycle_cnt} !== e) begin
        tests_failed++;
        $display("FAIL scoreboard @%0t: got pc=%0d run=%0b done=%0b cnt=%0d, want pc=%0d run=%0b done=%0b cnt=%0d",
                 $time, pc, running, done, cycle_cnt, e.pc, e.running, e.done, e.cnt);
      end
    end
  end

  task automatic model_reset();
    m_state = M_IDLE;
    m_pc    = 0;
    m_cnt   = 0;
    sb_q.delete();
  endtask

  // Drive one cycle of inputs at the falling edge, predict the result, and
  // return once outputs after the next rising edge are settled.
  task automatic step(input logic s, input logic [1:0] ps, input logic h,
                      input logic st, input logic be, input logic [3:0] bi);
    exp_t e;
    @(negedge clk);
    start = s; prog_sel = ps; halt = h; stall = st; branch_en = be; branch_idx = bi;
    if (s) begin
      m_state = M_RUN;
      m_pc    = SA[ps];
      m_cnt   = 0;
    end else if (m_state == M_RUN) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (h)        m_state = M_DONE;
      else if (st)  m_pc = m_pc;
      else if (be)  m_pc = LUT[bi];
      else          m_pc = (m_pc + 1) % 256;
    end
    e.pc      = 8'(m_pc);
    e.running = (m_state == M_RUN);
    e.done    = (m_state == M_DONE);
    e.cnt     = 16'(m_cnt);
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    tests_run++;
    if ({pc, running, done, cycle_cnt} !== 26'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got pc=%0d run=%0b done=%0b cnt=%0d, want all zero",
               pc, running, done, cycle_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    // In IDLE, decoder inputs must be ignored.
    step(1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 4'd3);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd6);
    tests_run++;
    if (pc !== 8'd0 || running !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_ignores_inputs: got pc=%0d run=%0b, want pc=0 run=0", pc, running);
    end
  endtask

  task automatic test_start_step();
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    tests_run++;
    if (pc !== 8'd27 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_prog1: got pc=%0d run=%0b, want pc=27 run=1", pc, running);
    end
    for (int i = 1; i <= 3; i++) begin
      idle_steps(1);
      tests_run++;
      if (pc !== 8'(27 + i)) begin
        tests_failed++;
        $display("FAIL step_pc: got %0d, want %0d", pc, 27 + i);
      end
    end
    tests_run++;
    if (cycle_cnt !== 16'd3 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL step_cnt: got cnt=%0d run=%0b, want cnt=3 run=1", cycle_cnt, running);
    end
  endtask

  task automatic test_branch();
    idle_steps(7);  // 30 -> 37
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd3);
    tests_run++;
    if (pc !== 8'd30) begin
      tests_failed++;
      $display("FAIL branch_idx3: got pc=%0d, want 30", pc);
    end
    idle_steps(7);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd3);
    tests_run++;
    if (pc !== 8'd37) begin
      tests_failed++;
      $display("FAIL stall_over_branch: got pc=%0d, want 37", pc);
    end
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd13);
    tests_run++;
    if (pc !== 8'd0) begin
      tests_failed++;
      $display("FAIL unused_lut_index: got pc=%0d, want 0", pc);
    end
  endtask

  task automatic test_halt();
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    idle_steps(26);
    step(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 4'd4);
    tests_run++;
    if (pc !== 8'd26 || done !== 1'b1 || running !== 1'b0 || cycle_cnt !== 16'd27) begin
      tests_failed++;
      $display("FAIL halt: got pc=%0d done=%0b run=%0b cnt=%0d, want pc=26 done=1 run=0 cnt=27",
               pc, done, running, cycle_cnt);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'(i));
    tests_run++;
    if (pc !== 8'd26 || done !== 1'b1 || cycle_cnt !== 16'd27) begin
      tests_failed++;
      $display("FAIL done_frozen: got pc=%0d done=%0b cnt=%0d, want pc=26 done=1 cnt=27",
               pc, done, cycle_cnt);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd10);
    idle_steps(197);  // 58 -> 255
    tests_run++;
    if (pc !== 8'd255) begin
      tests_failed++;
      $display("FAIL reach_255: got pc=%0d, want 255", pc);
    end
    idle_steps(1);
    tests_run++;
    if (pc !== 8'd0 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL pc_wrap: got pc=%0d run=%0b, want pc=0 run=1", pc, running);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4'd0);
    idle_steps(4);  // 46 -> 50
    rst = 1'b1;     // between edges
    #1;
    tests_run++;
    if ({pc, running, done, cycle_cnt} !== 26'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got pc=%0d run=%0b done=%0b cnt=%0d, want all zero",
               pc, running, done, cycle_cnt);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4'd0);
    tests_run++;
    if (pc !== 8'd46 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_prog2: got pc=%0d run=%0b, want pc=46 run=1", pc, running);
    end
  endtask

  task automatic test_start_priority();
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    idle_steps(10);
    step(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    tests_run++;
    if (pc !== 8'd0 || running !== 1'b1 || done !== 1'b0 || cycle_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL start_beats_halt: got pc=%0d run=%0b done=%0b cnt=%0d, want pc=0 run=1 done=0 cnt=0",
               pc, running, done, cycle_cnt);
    end
    idle_steps(5);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 4'd0);
    tests_run++;
    if (pc !== 8'd0 || running !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_from_done_sel3: got pc=%0d run=%0b done=%0b, want pc=0 run=1 done=0",
               pc, running, done);
    end
  endtask

  task automatic test_saturate();
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    idle_steps(65535);
    tests_run++;
    if (cycle_cnt !== 16'hffff) begin
      tests_failed++;
      $display("FAIL cnt_reach_max: got %0d, want 65535", cycle_cnt);
    end
    idle_steps(2);
    tests_run++;
    if (cycle_cnt !== 16'hffff) begin
      tests_failed++;
      $display("FAIL cnt_saturate: got %0d, want 65535", cycle_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; prog_sel = 2'd0; halt = 1'b0; stall = 1'b0;
    branch_en = 1'b0; branch_idx = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    test_reset();
    test_start_step();
    test_branch();
    test_halt();
    test_wrap();
    test_async_reset();
    test_start_priority();
    test_saturate();
    @(negedge clk);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
